// File: rtl/vx_warp_ctl_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vx_warp_ctl_driver                                           |
// | Description : Queued warp-control command driver and shadow warp state.    |
// |               Optional error checking: VX_WCTL_DRV_ERRCHK_EN.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module vx_warp_ctl_driver #(
  parameter int                 NUM_WARPS    = 4,
  parameter int                 NUM_THREADS  = 4,
  parameter int                 PC_BITS      = 30,
  parameter int                 FIFO_DEPTH   = 4,
  parameter int                 STALL_CYCLES = 2,
  parameter logic [PC_BITS-1:0] STARTUP_PC   = '0,
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int TID_W    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [NW_WIDTH-1:0]              cmd_wid,
  input  logic [NUM_THREADS-1:0]           cmd_tmask,
  input  logic [PC_BITS-1:0]               cmd_pc,
  output logic                             warp_ctl_valid,
  output logic [NUM_WARPS-1:0]             active_warps,
  output logic [NUM_WARPS-1:0]             stalled_warps,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  output logic [NUM_WARPS*PC_BITS-1:0]     warp_pcs,
  output logic [PC_BITS-1:0]               result_pc,
  output logic [NW_WIDTH-1:0]              wid,
  output logic [TID_W-1:0]                 last_tid,
  output logic                             busy
`ifdef VX_WCTL_DRV_ERRCHK_EN
  ,
  output logic                             err_sticky,
  output logic [7:0]                       err_count
`endif
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_STL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [c_STL_W-1:0] c_STL_INIT = c_STL_W'(STALL_CYCLES - 1);

  localparam logic [1:0] c_OP_ACTIVATE   = 2'd0;
  localparam logic [1:0] c_OP_DEACTIVATE = 2'd1;
  localparam logic [1:0] c_OP_TMC        = 2'd2;
  localparam logic [1:0] c_OP_BRANCH     = 2'd3;

  typedef struct packed {
    logic [1:0]             op;
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_BITS-1:0]     pc;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t                               r_state, w_state_nxt;
  logic   [c_PTR_W-1:0]                 r_wr_ptr, r_rd_ptr;
  logic   [c_CNT_W-1:0]                 r_count;
  cmd_t                                 r_fifo [FIFO_DEPTH];
  cmd_t                                 r_cmd;
  cmd_t                                 w_push_cmd;
  logic                                 w_full, w_push, w_pop;
  logic   [c_STL_W-1:0]                 r_stl_cnt, w_stl_cnt_nxt;
  logic                                 r_valid, w_valid_nxt;
  logic   [NUM_WARPS-1:0]               r_active, w_active_nxt;
  logic   [NUM_WARPS-1:0]               r_stalled, w_stalled_nxt;
  logic   [NUM_WARPS-1:0][NUM_THREADS-1:0] r_tmask, w_tmask_nxt;
  logic   [NUM_WARPS-1:0][PC_BITS-1:0]  r_pc, w_pc_nxt;
  logic   [PC_BITS-1:0]                 r_result_pc, w_result_pc_nxt;
  logic   [NW_WIDTH-1:0]                r_wid, w_wid_nxt;
  logic   [TID_W-1:0]                   r_last_tid, w_last_tid_nxt;
  logic                                 w_wid_ok, w_cur_act, w_exec_ok;
  logic                                 w_new_act;
  logic   [NUM_THREADS-1:0]             w_new_tmask;
  logic   [PC_BITS-1:0]                 w_new_pc;
`ifdef VX_WCTL_DRV_ERRCHK_EN
  logic                                 w_illegal;
  logic                                 r_err_sticky;
  logic   [7:0]                         r_err_count;
`endif

  function automatic logic [TID_W-1:0] f_hi_tid(input logic [NUM_THREADS-1:0] mask);
    f_hi_tid = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (mask[i]) f_hi_tid = TID_W'(i);
    end
  endfunction

  // ---------------------------------------------------------------- queue
  assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && cmd_ready;
  assign w_push_cmd = {cmd_op, cmd_wid, cmd_tmask, cmd_pc};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_cmd;
    if (w_pop)  r_cmd <= r_fifo[r_rd_ptr];
  end

  // ------------------------------------------------ effect of the command
  always_comb begin
    w_wid_ok    = (32'(r_cmd.wid) < NUM_WARPS);
    w_cur_act   = w_wid_ok && r_active[r_cmd.wid];
    w_new_act   = w_cur_act;
    w_new_tmask = w_wid_ok ? r_tmask[r_cmd.wid] : '0;
    w_new_pc    = w_wid_ok ? r_pc[r_cmd.wid] : '0;
    case (r_cmd.op)
      c_OP_ACTIVATE: begin
        w_new_act   = 1'b1;
        w_new_tmask = r_cmd.tmask;
        w_new_pc    = r_cmd.pc;
      end
      c_OP_DEACTIVATE: begin
        w_new_act   = 1'b0;
        w_new_tmask = '0;
      end
      c_OP_TMC: begin
        w_new_tmask = r_cmd.tmask;
        if (r_cmd.tmask == '0) w_new_act = 1'b0;
      end
      c_OP_BRANCH: begin
        w_new_pc = r_cmd.pc;
      end
      default: ;
    endcase
`ifdef VX_WCTL_DRV_ERRCHK_EN
    w_illegal = !w_wid_ok
             || (((r_cmd.op == c_OP_TMC) || (r_cmd.op == c_OP_BRANCH)) && !w_cur_act)
             || ((r_cmd.op == c_OP_ACTIVATE) && w_cur_act);
    w_exec_ok = !w_illegal;
`else
    w_exec_ok = w_wid_ok;
`endif
  end

  // ------------------------------------------------------------------ FSM
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_valid_nxt     = 1'b0;
    w_stl_cnt_nxt   = r_stl_cnt;
    w_active_nxt    = r_active;
    w_stalled_nxt   = r_stalled;
    w_tmask_nxt     = r_tmask;
    w_pc_nxt        = r_pc;
    w_result_pc_nxt = r_result_pc;
    w_wid_nxt       = r_wid;
    w_last_tid_nxt  = r_last_tid;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        // Discarded commands return straight to IDLE without a stall.
        w_state_nxt = S_IDLE;
        if (w_exec_ok) begin
          w_active_nxt[r_cmd.wid]  = w_new_act;
          w_tmask_nxt[r_cmd.wid]   = w_new_tmask;
          w_pc_nxt[r_cmd.wid]      = w_new_pc;
          w_stalled_nxt[r_cmd.wid] = 1'b1;
          w_result_pc_nxt          = w_new_pc;
          w_wid_nxt                = r_cmd.wid;
          w_last_tid_nxt           = f_hi_tid(w_new_tmask);
          w_valid_nxt              = 1'b1;
          w_stl_cnt_nxt            = c_STL_INIT;
          w_state_nxt              = S_STALL;
        end
      end
      S_STALL: begin
        if (r_stl_cnt == '0) begin
          w_stalled_nxt[r_cmd.wid] = 1'b0;
          w_state_nxt              = S_IDLE;
        end else begin
          w_stl_cnt_nxt = r_stl_cnt - c_STL_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_stl_cnt   <= '0;
      r_active    <= NUM_WARPS'(1);
      r_stalled   <= '0;
      r_tmask     <= '0;
      r_tmask[0]  <= NUM_THREADS'(1);
      r_pc        <= '0;
      r_pc[0]     <= STARTUP_PC;
      r_result_pc <= '0;
      r_wid       <= '0;
      r_last_tid  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= w_valid_nxt;
      r_stl_cnt   <= w_stl_cnt_nxt;
      r_active    <= w_active_nxt;
      r_stalled   <= w_stalled_nxt;
      r_tmask     <= w_tmask_nxt;
      r_pc        <= w_pc_nxt;
      r_result_pc <= w_result_pc_nxt;
      r_wid       <= w_wid_nxt;
      r_last_tid  <= w_last_tid_nxt;
    end
  end

`ifdef VX_WCTL_DRV_ERRCHK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if ((r_state == S_EXEC) && w_illegal) begin
      r_err_sticky <= 1'b1;
      if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;
`endif

  assign warp_ctl_valid = r_valid;
  assign active_warps   = r_active;
  assign stalled_warps  = r_stalled;
  assign thread_masks   = r_tmask;
  assign warp_pcs       = r_pc;
  assign result_pc      = r_result_pc;
  assign wid            = r_wid;
  assign last_tid       = r_last_tid;
  assign busy           = (r_state != S_IDLE) || (r_count != '0);

endmodule

`default_nettype wire
